// File: rtl/ntt_pkg.sv
// ntt_pkg: definitions shared by the NTT butterfly scheduler files.
//   ntt_state_t    : scheduler FSM states (IDLE, RUN, DRAIN, DONE)
//   NTT_N_LOG2     : default log2 of the polynomial length (256 coefficients)
//   Val_Q          : coefficient modulus used by the butterfly datapath
//   ntt_addr_t     : coefficient RAM address at the default length
//   ntt_zeta_idx_t : twiddle ROM index at the default length
package ntt_pkg;

    localparam int NTT_N_LOG2 = 8;
    localparam int Val_Q      = 8380417;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_t;

    typedef logic [NTT_N_LOG2-1:0] ntt_addr_t;
    typedef logic [NTT_N_LOG2-1:0] ntt_zeta_idx_t;

endpackage

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay: delays the butterfly issue strobe and its coefficient pair
// addresses by DEPTH cycles so they line up with the butterfly unit's result.
// The line shifts every cycle; only the valid bits are reset, and the address
// outputs are forced to zero whenever the delayed valid is low.
// DEPTH = 0 makes the block a combinational pass-through.
// Ports:
//   clk_i, reset_i         : clock, synchronous active-high reset
//   vld_i, addr1_i, addr2_i: issue strobe and pair addresses entering the line
//   vld_o, addr1_o, addr2_o: the same, DEPTH cycles later
module ntt_wb_delay
    import ntt_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = NTT_N_LOG2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          vld_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [AW-1:0] addr2_i,
    output logic          vld_o,
    output logic [AW-1:0] addr1_o,
    output logic [AW-1:0] addr2_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk;
            assign w_unused_clk = clk_i ^ reset_i;
            assign vld_o   = vld_i;
            assign addr1_o = addr1_i;
            assign addr2_o = addr2_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] r_vld_p;
            logic [AW-1:0]    r_addr1_p [DEPTH];
            logic [AW-1:0]    r_addr2_p [DEPTH];

            // valid line: reset so no stale write-back survives a reset
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_vld_p <= '0;
                end else begin
                    r_vld_p[0] <= vld_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld_p[i] <= r_vld_p[i-1];
                    end
                end
            end

            // address line: free-running, qualified by the valid line
            always_ff @(posedge clk_i) begin
                r_addr1_p[0] <= addr1_i;
                r_addr2_p[0] <= addr2_i;
                for (int i = 1; i < DEPTH; i++) begin
                    r_addr1_p[i] <= r_addr1_p[i-1];
                    r_addr2_p[i] <= r_addr2_p[i-1];
                end
            end

            assign vld_o   = r_vld_p[DEPTH-1];
            assign addr1_o = r_vld_p[DEPTH-1] ? r_addr1_p[DEPTH-1] : '0;
            assign addr2_o = r_vld_p[DEPTH-1] ? r_addr2_p[DEPTH-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/ntt_bu_scheduler.sv
// ntt_bu_scheduler: issues the N_LOG2 * 2^(N_LOG2-1) butterflies of an
// in-place NTT, one pair per RUN cycle, and replays each issue as a
// write-back strobe BU_LATENCY cycles later.
//   inv_i = 0 : forward Cooley-Tukey order, len = HALF >> s,
//               zeta index = (1 << s) + group (ascending 1..N-1)
//   inv_i = 1 : inverse Gentleman-Sande order, len = 1 << s,
//               zeta index = ((N >> s) - 1) - group (descending N-1..1)
//   Pair addresses: addr1 = group*2*len + (b mod len), addr2 = addr1 + len.
// Optional feature macro NTT_SCHED_STALL_EN adds input stall_i, which holds
// issue (and the s/b counters) while high in RUN. Without it, issue never stalls.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   start_i, inv_i          : start request (IDLE only) and direction, captured together
//   stall_i                 : issue hold (only with NTT_SCHED_STALL_EN)
//   rd_en_o, rd_addr1/2_o   : butterfly issue strobe and coefficient pair to read
//   zeta_idx_o, is_GS_BU_o  : twiddle ROM index and butterfly mode for the issue
//   wr_en_o, wr_addr1/2_o   : write-back strobe and pair, BU_LATENCY cycles after issue
//   busy_o, done_o          : transform in progress, one-cycle completion pulse
module ntt_bu_scheduler
    import ntt_pkg::*;
#(
    parameter int N_LOG2     = NTT_N_LOG2,
    parameter int BU_LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              inv_i,
`ifdef NTT_SCHED_STALL_EN
    input  logic              stall_i,
`endif
    output logic              rd_en_o,
    output logic [N_LOG2-1:0] rd_addr1_o,
    output logic [N_LOG2-1:0] rd_addr2_o,
    output logic [N_LOG2-1:0] zeta_idx_o,
    output logic              is_GS_BU_o,
    output logic              wr_en_o,
    output logic [N_LOG2-1:0] wr_addr1_o,
    output logic [N_LOG2-1:0] wr_addr2_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int SW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
    localparam int BW = N_LOG2 - 1;

    localparam logic [SW-1:0]     S_LAST   = SW'(N_LOG2 - 1);
    localparam logic [BW-1:0]     B_LAST   = '1;
    localparam logic [2:0]        D_LAST   = 3'(BU_LATENCY - 1);
    localparam bit                NO_DRAIN = (BU_LATENCY == 0);
    localparam logic [N_LOG2-1:0] ONE      = N_LOG2'(1);
    localparam logic [N_LOG2-1:0] ALL1     = '1;
    localparam logic [N_LOG2-1:0] HALF     = ONE << (N_LOG2 - 1);

    ntt_state_t r_state;
    ntt_state_t w_state_nxt;

    logic [SW-1:0] r_s;
    logic [BW-1:0] r_b;
    logic [2:0]    r_dcnt;
    logic          r_inv;

    logic w_stall;
    logic w_issue;
    logic w_last_b;
    logic w_last_s;
    logic w_drain_end;

    logic [N_LOG2-1:0] w_bx;
    logic [N_LOG2-1:0] w_len;
    logic [N_LOG2-1:0] w_g;
    logic [N_LOG2-1:0] w_a1;
    logic [N_LOG2-1:0] w_a2;
    logic [N_LOG2-1:0] w_zeta;

`ifdef NTT_SCHED_STALL_EN
    assign w_stall = stall_i;
`else
    assign w_stall = 1'b0;
`endif

    assign w_last_b    = (r_b == B_LAST);
    assign w_last_s    = (r_s == S_LAST);
    assign w_drain_end = (r_dcnt == D_LAST);

    // ---- FSM state register ----
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM next state and status outputs ----
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (!w_stall) begin
                    w_issue = 1'b1;
                    if (w_last_b) begin
                        // zero-latency units skip DRAIN entirely
                        if (NO_DRAIN) begin
                            w_state_nxt = w_last_s ? ST_DONE : ST_RUN;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (w_drain_end) begin
                    w_state_nxt = w_last_s ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---- stage / butterfly / drain counters ----
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s    <= '0;
            r_b    <= '0;
            r_dcnt <= '0;
            r_inv  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_s   <= '0;
                        r_b   <= '0;
                        r_inv <= inv_i;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        // b wraps to 0 after the last butterfly of a stage
                        r_b    <= r_b + 1'b1;
                        r_dcnt <= '0;
                        if (w_last_b && NO_DRAIN && !w_last_s) begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_dcnt <= r_dcnt + 1'b1;
                    if (w_drain_end && !w_last_s) begin
                        r_s <= r_s + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---- pair address and twiddle index for the current (s, b) ----
    always_comb begin
        w_bx   = {1'b0, r_b};
        w_len  = '0;
        w_g    = '0;
        w_a1   = '0;
        w_zeta = '0;
        if (r_inv) begin
            w_len  = ONE << r_s;
            w_g    = w_bx >> r_s;
            w_a1   = (w_g << (r_s + 1)) | (w_bx & (w_len - ONE));
            // (N >> s) - 1 is all-ones shifted right by s
            w_zeta = (ALL1 >> r_s) - w_g;
        end else begin
            w_len  = HALF >> r_s;
            w_g    = w_bx >> (BW - r_s);
            w_a1   = (w_g << (N_LOG2 - r_s)) | (w_bx & (w_len - ONE));
            w_zeta = (ONE << r_s) + w_g;
        end
        // bit log2(len) of addr1 is always clear, so this add never carries
        w_a2 = w_a1 + w_len;
    end

    assign rd_en_o    = w_issue;
    assign rd_addr1_o = w_issue ? w_a1 : '0;
    assign rd_addr2_o = w_issue ? w_a2 : '0;
    assign zeta_idx_o = w_issue ? w_zeta : '0;
    assign is_GS_BU_o = busy_o & r_inv;

    // ---- write-back alignment with the butterfly pipeline ----
    ntt_wb_delay #(
        .DEPTH (BU_LATENCY),
        .AW    (N_LOG2)
    ) u_wb_delay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .vld_i   (rd_en_o),
        .addr1_i (rd_addr1_o),
        .addr2_i (rd_addr2_o),
        .vld_o   (wr_en_o),
        .addr1_o (wr_addr1_o),
        .addr2_o (wr_addr2_o)
    );

endmodule

// File: tb/tb_ntt_bu_scheduler.sv
module tb_ntt_bu_scheduler;

    localparam int NL     = 8;
    localparam int N      = 256;
    localparam int HALF   = 128;
    localparam int L      = 2;
    localparam int T_DONE = 1 + NL * (HALF + L);
    localparam int MAXC   = 16384;
`ifdef NTT_SCHED_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_drv = 1'b1;
    logic start_drv = 1'b0;
    logic inv_drv   = 1'b0;
    logic stall_drv = 1'b0;
    logic stall_eff;
    assign stall_eff = stall_drv & STALL_ON;

    logic          rd_en_o, is_GS_BU_o, wr_en_o, busy_o, done_o;
    logic [NL-1:0] rd_addr1_o, rd_addr2_o, zeta_idx_o, wr_addr1_o, wr_addr2_o;

    ntt_bu_scheduler #(.N_LOG2(NL), .BU_LATENCY(L)) dut (
        .clk_i      (clk),
        .reset_i    (reset_drv),
        .start_i    (start_drv),
        .inv_i      (inv_drv),
`ifdef NTT_SCHED_STALL_EN
        .stall_i    (stall_drv),
`endif
        .rd_en_o    (rd_en_o),
        .rd_addr1_o (rd_addr1_o),
        .rd_addr2_o (rd_addr2_o),
        .zeta_idx_o (zeta_idx_o),
        .is_GS_BU_o (is_GS_BU_o),
        .wr_en_o    (wr_en_o),
        .wr_addr1_o (wr_addr1_o),
        .wr_addr2_o (wr_addr2_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference issue order from the textbook NTT loop nests
    int fa1[NL*HALF], fa2[NL*HALF], fz[NL*HALF];
    int ia1[NL*HALF], ia2[NL*HALF], iz[NL*HALF];

    // timeline model: t counts cycles since the accepted start
    bit chk_on = 1'b0;
    bit m_act  = 1'b0;
    int m_t    = 0;
    bit m_inv  = 1'b0;
    int cyc    = 0;
    int rst_cyc = 0;

    logic          hist_en [MAXC];
    logic [NL-1:0] hist_a1 [MAXC];
    logic [NL-1:0] hist_a2 [MAXC];

    function automatic bit in_run(input int t);
        int u;
        if (t < 1) return 1'b0;
        u = t - 1;
        return ((u / (HALF + L)) < NL) && ((u % (HALF + L)) < HALF);
    endfunction

    function automatic int idx_of(input int t);
        int u;
        u = t - 1;
        return (u / (HALF + L)) * HALF + (u % (HALF + L));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset_drv) begin
            m_act   = 1'b0;
            m_t     = 0;
            rst_cyc = cyc;
        end else if (m_act) begin
            if (m_t == T_DONE) m_act = 1'b0;
            else if (!(in_run(m_t) && stall_eff)) m_t++;
        end else if (start_drv) begin
            m_act = 1'b1;
            m_t   = 1;
            m_inv = inv_drv;
        end
    end

    logic          e_rd, e_wr, e_busy, e_done, e_gs;
    logic [NL-1:0] e_a1, e_a2, e_z, e_w1, e_w2;
    int            e_k, e_j;

    always @(negedge clk) begin
        if (chk_on) begin
            e_rd = m_act && (m_t < T_DONE) && in_run(m_t) && !stall_eff;
            e_a1 = '0; e_a2 = '0; e_z = '0;
            if (e_rd) begin
                e_k  = idx_of(m_t);
                e_a1 = m_inv ? NL'(ia1[e_k]) : NL'(fa1[e_k]);
                e_a2 = m_inv ? NL'(ia2[e_k]) : NL'(fa2[e_k]);
                e_z  = m_inv ? NL'(iz[e_k])  : NL'(fz[e_k]);
            end
            e_busy = m_act && (m_t < T_DONE);
            e_done = m_act && (m_t == T_DONE);
            e_gs   = e_busy && m_inv;
            if (cyc < MAXC) begin
                hist_en[cyc] = e_rd;
                hist_a1[cyc] = e_a1;
                hist_a2[cyc] = e_a2;
            end
            e_j  = cyc - L;
            e_wr = 1'b0; e_w1 = '0; e_w2 = '0;
            if (e_j >= 0 && e_j >= rst_cyc && e_j < MAXC) begin
                if (hist_en[e_j]) begin
                    e_wr = 1'b1;
                    e_w1 = hist_a1[e_j];
                    e_w2 = hist_a2[e_j];
                end
            end
            n_vec++;
            if ({rd_en_o, rd_addr1_o, rd_addr2_o, zeta_idx_o, is_GS_BU_o, wr_en_o,
                 wr_addr1_o, wr_addr2_o, busy_o, done_o} !==
                {e_rd, e_a1, e_a2, e_z, e_gs, e_wr, e_w1, e_w2, e_busy, e_done}) begin
                n_err++;
                $display("FAIL cycle_%0d: got rd=%b %0d/%0d z=%0d gs=%b wr=%b %0d/%0d busy=%b done=%b, expected rd=%b %0d/%0d z=%0d gs=%b wr=%b %0d/%0d busy=%b done=%b",
                         cyc, rd_en_o, rd_addr1_o, rd_addr2_o, zeta_idx_o, is_GS_BU_o, wr_en_o,
                         wr_addr1_o, wr_addr2_o, busy_o, done_o,
                         e_rd, e_a1, e_a2, e_z, e_gs, e_wr, e_w1, e_w2, e_busy, e_done);
            end
        end
    end

    task automatic run_xform(input bit inv, input bit do_stall);
        int lat, n_iss, gap, res_lat, res_a1, bad;
        int f1, f2, fzz, s1, s2, sz, l1, l2, lz, fgs;
        int touches[N];
        lat = 0; n_iss = 0; gap = 0; res_lat = -1; res_a1 = -1; bad = 0;
        f1 = -1; f2 = -1; fzz = -1; s1 = -1; s2 = -1; sz = -1; l1 = -1; l2 = -1; lz = -1; fgs = -1;
        for (int i = 0; i < N; i++) touches[i] = 0;
        @(posedge clk); #1;
        start_drv = 1'b1;
        inv_drv   = inv;
        @(posedge clk); #1;
        start_drv = 1'b0;
        while (lat < 3000) begin
            @(negedge clk);
            lat++;
            if (done_o === 1'b1) break;
            if (do_stall && lat >= 41 && lat <= 45 && rd_en_o === 1'b0) gap++;
            if (rd_en_o === 1'b1) begin
                if (n_iss == 0) begin
                    f1 = int'(rd_addr1_o); f2 = int'(rd_addr2_o); fzz = int'(zeta_idx_o);
                    fgs = int'(is_GS_BU_o);
                end
                if (n_iss == 40) begin res_lat = lat; res_a1 = int'(rd_addr1_o); end
                if (n_iss == 7 * HALF) begin
                    s1 = int'(rd_addr1_o); s2 = int'(rd_addr2_o); sz = int'(zeta_idx_o);
                end
                l1 = int'(rd_addr1_o); l2 = int'(rd_addr2_o); lz = int'(zeta_idx_o);
                touches[int'(rd_addr1_o)]++;
                touches[int'(rd_addr2_o)]++;
                n_iss++;
            end
            @(posedge clk); #1;
            inv_drv   = 1'($urandom);
            start_drv = (lat == 500);
            stall_drv = do_stall && (lat >= 40) && (lat < 45);
        end
        start_drv = 1'b0;
        stall_drv = 1'b0;
        chk("done_latency", lat, T_DONE + (do_stall ? 5 : 0));
        chk("issue_count", n_iss, NL * HALF);
        chk("first_gs", fgs, int'(inv));
        for (int i = 0; i < N; i++) if (touches[i] != 2 * NL / 2) bad++;
        chk("addr_touch_once_per_stage", bad, 0);
        if (!inv) begin
            chk("fwd_first_a1", f1, 0);
            chk("fwd_first_a2", f2, 128);
            chk("fwd_first_zeta", fzz, 1);
            chk("fwd_last_a1", l1, 254);
            chk("fwd_last_a2", l2, 255);
            chk("fwd_last_zeta", lz, 255);
        end else begin
            chk("inv_first_a1", f1, 0);
            chk("inv_first_a2", f2, 1);
            chk("inv_first_zeta", fzz, 255);
            chk("inv_s7_a1", s1, 0);
            chk("inv_s7_a2", s2, 128);
            chk("inv_s7_zeta", sz, 1);
        end
        if (do_stall) begin
            chk("stall_gap", gap, 5);
            chk("stall_resume_lat", res_lat, 46);
            chk("stall_resume_a1", res_a1, 40);
        end
    endtask

    initial begin
        int idx, z;
        idx = 0; z = 1;
        for (int len = HALF; len >= 1; len = len / 2) begin
            for (int st = 0; st < N; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    fa1[idx] = j; fa2[idx] = j + len; fz[idx] = z; idx++;
                end
                z++;
            end
        end
        idx = 0; z = N - 1;
        for (int len = 1; len <= HALF; len = len * 2) begin
            for (int st = 0; st < N; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    ia1[idx] = j; ia2[idx] = j + len; iz[idx] = z; idx++;
                end
                z--;
            end
        end

        // reset state
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_ctrl", int'({rd_en_o, wr_en_o, busy_o, done_o, is_GS_BU_o}), 0);
        chk("reset_rd_addr", int'({rd_addr1_o, rd_addr2_o, zeta_idx_o}), 0);
        repeat (2) @(posedge clk);
        #1 reset_drv = 1'b0;

        run_xform(1'b0, 1'b0);
        run_xform(1'b1, 1'b0);

        // reset in the middle of a forward run
        @(posedge clk); #1;
        start_drv = 1'b1; inv_drv = 1'b0;
        @(posedge clk); #1;
        start_drv = 1'b0;
        repeat (300) @(negedge clk);
        @(posedge clk); #1;
        reset_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ctrl", int'({rd_en_o, wr_en_o, busy_o, done_o, is_GS_BU_o}), 0);
        chk("midrst_rd_addr", int'({rd_addr1_o, rd_addr2_o, zeta_idx_o}), 0);
        chk("midrst_wr_addr", int'({wr_addr1_o, wr_addr2_o}), 0);
        @(posedge clk); #1;
        reset_drv = 1'b0;
        for (int i = 0; i < L + 3; i++) begin
            @(negedge clk);
            chk("midrst_no_wb", int'({wr_en_o, rd_en_o}), 0);
        end

        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_xform(1'($urandom), 1'b0);
        end

        if (STALL_ON) run_xform(1'b0, 1'b1);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
